// File: rtl/transpose_chunk_seq.sv
// transpose_chunk_seq: walks every CHUNK_SIZE x CHUNK_SIZE tile of an
// ARR_SIZE x ARR_SIZE matrix and streams each tile's top-left byte address
// over a valid/ready handshake toward address_calc.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; all outputs low
// RUN   | presenting chunk_addr; each fire advances to the next tile
// DONE  | one-cycle done pulse after the final fire, then IDLE
module transpose_chunk_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int ARR_SIZE   = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CHUNK_SIZE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  chunk_valid,
  input  logic                  chunk_ready,
  output logic [ADDR_WIDTH-1:0] chunk_addr,
  output logic                  chunk_last,
  output logic                  busy,
  output logic                  done
);

  localparam int EB    = DATA_WIDTH / 8;
  localparam int T     = ARR_SIZE / CHUNK_SIZE;
  localparam int IDX_W = (T > 1) ? $clog2(T) : 1;

  // Strides are reduced mod 2^ADDR_WIDTH; the address math wraps anyway.
  localparam logic [ADDR_WIDTH-1:0] COL_STRIDE = ADDR_WIDTH'(CHUNK_SIZE * EB);
  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(CHUNK_SIZE * ARR_SIZE * EB);
  localparam logic [IDX_W-1:0]      IDX_MAX    = IDX_W'(T - 1);
  localparam logic                  ONE_TILE   = (T == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic                  mode_q;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      c_idx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] line_base_q;

  logic                  fire;
  logic [ADDR_WIDTH-1:0] inner_stride;
  logic [ADDR_WIDTH-1:0] outer_stride;
  logic [IDX_W-1:0]      inner_idx;
  logic [IDX_W-1:0]      outer_idx;
  logic                  inner_wrap;
  logic [IDX_W-1:0]      inner_nxt;
  logic [IDX_W-1:0]      outer_nxt;
  logic [IDX_W-1:0]      r_nxt;
  logic [IDX_W-1:0]      c_nxt;
  logic [ADDR_WIDTH-1:0] line_base_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;

  assign chunk_addr = addr_q;

  // Next tile position and running address; mode swaps which counter/stride is inner.
  always_comb begin
    fire          = chunk_valid & chunk_ready;
    inner_stride  = mode_q ? ROW_STRIDE : COL_STRIDE;
    outer_stride  = mode_q ? COL_STRIDE : ROW_STRIDE;
    inner_idx     = mode_q ? r_idx : c_idx;
    outer_idx     = mode_q ? c_idx : r_idx;
    inner_wrap    = (inner_idx == IDX_MAX);
    inner_nxt     = inner_wrap ? '0 : inner_idx + 1'b1;
    outer_nxt     = inner_wrap ? outer_idx + 1'b1 : outer_idx;
    r_nxt         = mode_q ? inner_nxt : outer_nxt;
    c_nxt         = mode_q ? outer_nxt : inner_nxt;
    line_base_nxt = line_base_q + outer_stride;
    addr_nxt      = inner_wrap ? line_base_nxt : addr_q + inner_stride;
  end

  // Sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mode_q      <= 1'b0;
      r_idx       <= '0;
      c_idx       <= '0;
      addr_q      <= '0;
      line_base_q <= '0;
      chunk_valid <= 1'b0;
      chunk_last  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_q      <= mode;
            r_idx       <= '0;
            c_idx       <= '0;
            addr_q      <= base_addr;
            line_base_q <= base_addr;
            chunk_valid <= 1'b1;
            chunk_last  <= ONE_TILE;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          if (fire) begin
            if (chunk_last) begin
              // Return the address bus to zero so IDLE presents all-low outputs.
              chunk_valid <= 1'b0;
              chunk_last  <= 1'b0;
              addr_q      <= '0;
              r_idx       <= '0;
              c_idx       <= '0;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              r_idx      <= r_nxt;
              c_idx      <= c_nxt;
              addr_q     <= addr_nxt;
              chunk_last <= (r_nxt == IDX_MAX) && (c_nxt == IDX_MAX);
              if (inner_wrap) begin
                line_base_q <= line_base_nxt;
              end
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          chunk_valid <= 1'b0;
          chunk_last  <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transpose_chunk_seq.sv
// Testbench for transpose_chunk_seq: directed sweeps from the test plan plus
// randomized sweeps, each checked against an arithmetic tile-address model.
module tb_transpose_chunk_seq;

  localparam int DATA_WIDTH = 32;
  localparam int ARR_SIZE   = 8;
  localparam int ADDR_WIDTH = 8;
  localparam int CHUNK_SIZE = 2;
  localparam int EB         = DATA_WIDTH / 8;
  localparam int T          = ARR_SIZE / CHUNK_SIZE;
  localparam int NN         = T * T;
  localparam int COL_S      = CHUNK_SIZE * EB;
  localparam int ROW_S      = CHUNK_SIZE * ARR_SIZE * EB;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  mode;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  chunk_valid;
  logic                  chunk_ready;
  logic [ADDR_WIDTH-1:0] chunk_addr;
  logic                  chunk_last;
  logic                  busy;
  logic                  done;

  int n_vec = 0;
  int n_err = 0;

  transpose_chunk_seq #(
    .DATA_WIDTH(DATA_WIDTH),
    .ARR_SIZE  (ARR_SIZE),
    .ADDR_WIDTH(ADDR_WIDTH),
    .CHUNK_SIZE(CHUNK_SIZE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .base_addr  (base_addr),
    .chunk_valid(chunk_valid),
    .chunk_ready(chunk_ready),
    .chunk_addr (chunk_addr),
    .chunk_last (chunk_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // k-th tile of the sweep: row-major walks columns first, column-major rows first.
  function automatic int exp_addr(input int b, input int m, input int k);
    int r, c;
    if (m == 0) begin
      r = k / T;
      c = k % T;
    end else begin
      c = k / T;
      r = k % T;
    end
    return (b + r * ROW_S + c * COL_S) % (1 << ADDR_WIDTH);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // kind: 0 ready always high, 1 ready pattern 0,0,1, 2 random ready.
  // hazard: pulse start with base 100 during the sweep.
  task automatic run_sweep(input int b, input int m, input int kind, input int hazard);
    int   k = 0;
    int   cyc = 0;
    bit   fired_last = 0;
    logic rdy;
    @(negedge clk);
    start = 1'b1;
    base_addr = 8'(b);
    mode = 1'(m);
    @(negedge clk);
    start = 1'b0;
    while (!fired_last && cyc < 400) begin
      base_addr = 8'($urandom);
      mode = 1'($urandom);
      chk("valid", 32'(chunk_valid), 32'd1);
      chk("addr", 32'(chunk_addr), 32'(exp_addr(b, m, k)));
      chk("last", 32'(chunk_last), 32'(k == NN - 1));
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_run", 32'(done), 32'd0);
      case (kind)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 2);
        default: rdy = 1'($urandom);
      endcase
      chunk_ready = rdy;
      if (hazard != 0 && k == 3) begin
        start = 1'b1;
        base_addr = 8'd100;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      if (rdy) begin
        if (k == NN - 1) fired_last = 1;
        k++;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    chunk_ready = 1'b0;
    if (!fired_last) begin
      chk("sweep_timeout", 32'd0, 32'd1);
    end else begin
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_in_done", 32'(busy), 32'd1);
      chk("valid_in_done", 32'(chunk_valid), 32'd0);
      if (kind == 0) chk("done_latency", 32'(cyc), 32'(NN));
      if (kind == 1) chk("done_latency_bp", 32'(cyc), 32'(3 * NN));
      @(negedge clk);
      chk("done_cleared", 32'(done), 32'd0);
      chk("busy_cleared", 32'(busy), 32'd0);
      chk("valid_idle", 32'(chunk_valid), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    base_addr = '0;
    chunk_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(chunk_valid), 32'd0);
    chk("rst_addr", 32'(chunk_addr), 32'd0);
    chk("rst_last", 32'(chunk_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    // Ready during IDLE must not start anything.
    chunk_ready = 1'b1;
    @(negedge clk);
    chk("idle_ready_valid", 32'(chunk_valid), 32'd0);
    chunk_ready = 1'b0;

    run_sweep(0, 0, 0, 0);
    run_sweep(0, 1, 0, 0);
    run_sweep(200, 0, 0, 0);
    run_sweep(0, 0, 1, 0);
    run_sweep(0, 0, 0, 1);

    // Reset mid-sweep after the 5th fire with a handshake still pending.
    @(negedge clk);
    start = 1'b1;
    base_addr = 8'd0;
    mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chunk_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("pre_rst_addr", 32'(chunk_addr), 32'(exp_addr(0, 0, i)));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(chunk_valid), 32'd0);
    chk("midrst_addr", 32'(chunk_addr), 32'd0);
    chk("midrst_last", 32'(chunk_last), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    rst = 1'b0;
    chunk_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_valid", 32'(chunk_valid), 32'd0);
    end

    run_sweep(0, 0, 0, 0);

    for (int s = 0; s < 6; s++) begin
      run_sweep(int'($urandom_range(255, 0)), int'($urandom_range(1, 0)), 2, s % 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/transpose_chunk_seq.md
# transpose_chunk_seq

Chunk-address sequencer for the matrix-transpose datapath. On a start request it walks every CHUNK_SIZE x CHUNK_SIZE tile of an ARR_SIZE x ARR_SIZE matrix stored at a byte base address. It emits one tile's top-left byte address per valid/ready handshake. The stream drives the `chunk_addr` input of `address_calc`, which computes the transposed store address, so this block is the producing end of that interface.

## Interface
- DATA_WIDTH, 32, element width in bits; bytes per element EB = DATA_WIDTH/8
- ARR_SIZE, 8, matrix side length in elements
- ADDR_WIDTH, 8, byte-address width
- CHUNK_SIZE, 2, tile side length in elements; must divide ARR_SIZE; T = ARR_SIZE/CHUNK_SIZE tiles per side
- clk  in  1  clock; one clock domain, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a sweep; sampled only in IDLE
- mode  in  1  tile order: 0 = row-major, 1 = column-major; latched with start
- base_addr  in  ADDR_WIDTH  matrix byte base; latched with start
- chunk_valid  out  1  chunk_addr is valid
- chunk_ready  in  1  consumer accepts chunk_addr
- chunk_addr  out  ADDR_WIDTH  tile top-left byte address
- chunk_last  out  1  current chunk is the final tile of the sweep
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse after the last handshake

## Operation
- Strides, computed at elaboration:
  - COL_STRIDE = CHUNK_SIZE*EB
  - ROW_STRIDE = CHUNK_SIZE*ARR_SIZE*EB
- Tile (r,c) address = base + r*ROW_STRIDE + c*COL_STRIDE, computed mod 2^ADDR_WIDTH. Carries out of ADDR_WIDTH are discarded.
- Counters: r_idx and c_idx, each ceil(log2(T)) bits wide, minimum 1 bit.
- Row-major order (mode 0):
  - c_idx increments on each fire.
  - When c_idx = T-1, c_idx wraps to 0 and r_idx increments.
- Column-major order (mode 1): r_idx is the inner counter and c_idx the outer counter.
- chunk_addr comes from a running-address register, not a multiplier:
  - Inner-counter step: add the inner stride.
  - Inner wrap: reload from an outer-line base register, then add the outer stride.
- FSM states:
  - IDLE: outputs low. When start=1, latch base_addr and mode, clear counters, load the address register with base_addr, and go to RUN.
  - RUN: chunk_valid=1. A fire (chunk_valid & chunk_ready) advances the counters. Fire while chunk_last=1 goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- chunk_last = 1 when r_idx = T-1 and c_idx = T-1.
- start in RUN or DONE is ignored. A new sweep needs start asserted while in IDLE.
- mode and base_addr changes after latching have no effect until the next accepted start.

## Timing
- Reset values: state IDLE; chunk_valid, chunk_last, busy and done = 0; chunk_addr = 0; counters = 0.
- Reset takes effect at the next rising edge in any state, including mid-sweep with a handshake pending. The in-flight chunk is dropped and no done pulse occurs.
- Latency:
  - The start edge is edge 0; chunk_valid=1 with chunk_addr=base from edge 1.
  - With chunk_ready held high, one chunk per cycle; T*T chunks take T*T cycles.
  - done asserts the cycle after the last fire.
  - busy deasserts the cycle after done, so start is accepted again 2 cycles after the last fire.
- Backpressure: while chunk_valid=1 and chunk_ready=0, chunk_addr and chunk_last hold stable. chunk_valid never drops before a fire.
- chunk_ready is ignored while chunk_valid=0.
- Outputs are registered. There is no combinational path from chunk_ready to chunk_valid or chunk_addr.
- Degenerate case T=1: one chunk with chunk_last=1 on the first valid cycle.

## Test plan
All scenarios use default parameters, giving T=4, COL_STRIDE=8, ROW_STRIDE=64.
- Row-major sweep: base=0, mode=0, ready held high -> 16 chunks in 16 consecutive cycles:
  - 0, 8, 16, 24, 64, 72, 80, 88, 128, 136, 144, 152, 192, 200, 208, 216
  - chunk_last only on 216; done pulses 1 cycle later; busy low 1 cycle after that.
- Column-major sweep: base=0, mode=1 -> 0, 64, 128, 192, 8, 72, 136, 200, 16, ..., 152, 216. Last chunk is 216.
- Wrap-around: base=200, mode=0 -> 200, 208, 216, 224, 8, 16, 24, 32, 72, ...; all values mod 256. Final chunk is 160.
- Backpressure: ready toggles 0,0,1 repeating -> each address holds 3 cycles with no skipped or duplicated address. Sequence matches the row-major sweep; done occurs 48 cycles after the first valid.
- Control hazards:
  - start pulsed mid-sweep with base=100 -> ignored; sequence and latched base unchanged.
  - rst asserted after the 5th fire -> next edge all outputs 0 and state IDLE; no done pulse.
  - A fresh start after reset restarts the sweep from base.
